hub75_scan_ctrl: RTL and testbench

// Scan sequencer for a HUB75 LED matrix panel with 1/16 scan and dual-half rows (upper pair R0/G0/B0, lower pair R1/G1/B1).

---
 rtl/hub75_scan_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/16-scan sequencer: fetches framebuffer words, shifts one bit plane per row pair
// into the panel, then holds OE low for a plane-weighted time (binary-coded modulation).
module hub75_scan_ctrl #(
    parameter int COLS         = 32,
    parameter int ROWS_HALF    = 16,
    parameter int BIT_DEPTH    = 4,
    parameter int CLK_DIV      = 1,
    parameter int OE_BASE      = 32,
    parameter int BLANK_CYCLES = 2,
    parameter int AW           = $clog2(ROWS_HALF * COLS)
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     EN_I,
    output logic                     RD_EN_O,
    output logic [AW-1:0]            RD_ADDR_O,
    input  logic [6*BIT_DEPTH-1:0]   RD_DATA_I,
    output logic                     R0,
    output logic                     G0,
    output logic                     B0,
    output logic                     R1,
    output logic                     G1,
    output logic                     B1,
    output logic                     RA,
    output logic                     RB,
    output logic                     RC,
    output logic                     RD,
    output logic                     CLK_O,
    output logic                     LATCH,
    output logic                     OE,
    output logic                     FRAME_START_O,
    output logic                     BUSY_O,
    output logic [2:0]               dbg_state_o
);

    localparam int RW       = (ROWS_HALF > 1) ? $clog2(ROWS_HALF) : 1;
    localparam int PW       = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
    localparam int XW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW       = $clog2(2 * CLK_DIV + 1);
    localparam int DISP_MAX = OE_BASE << (BIT_DEPTH - 1);
    localparam int CNT_MAX  = (DISP_MAX > BLANK_CYCLES) ? DISP_MAX : BLANK_CYCLES;
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_BLANK   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [PW-1:0]   plane_q, plane_d;
    logic [XW-1:0]   col_q, col_d;
    logic [SW-1:0]   sub_q, sub_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      ra_q, ra_d;
    logic [5:0]      color_q, color_d;

    logic [BIT_DEPTH-1:0] r0_f, g0_f, b0_f, r1_f, g1_f, b1_f;
    logic [5:0]           plane_bits;
    logic [CW-1:0]        disp_last;

    // Read port: RD_EN_O is a one-cycle strobe with RD_ADDR_O; RD_DATA_I holds that word
    // on the following cycle (fixed latency, no back-pressure).
    assign {r0_f, g0_f, b0_f, r1_f, g1_f, b1_f} = RD_DATA_I;
    assign plane_bits = {r0_f[plane_q], g0_f[plane_q], b0_f[plane_q],
                         r1_f[plane_q], g1_f[plane_q], b1_f[plane_q]};
    assign disp_last  = CW'((OE_BASE << plane_q) - 1);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        plane_d = plane_q;
        col_d   = col_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        ra_d    = ra_q;
        color_d = color_q;
        RD_EN_O = 1'b0;
        CLK_O   = 1'b0;
        LATCH   = 1'b0;
        OE      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (EN_I) begin
                    state_d = ST_SHIFT;
                    row_d   = '0;
                    plane_d = '0;
                    col_d   = '0;
                    sub_d   = '0;
                end
            end
            ST_SHIFT: begin
                RD_EN_O = (sub_q == '0);
                CLK_O   = (sub_q > SW'(CLK_DIV));
                // Data arrives in the first low cycle; showing it combinationally keeps
                // the colour pins settled for the whole low phase before CLK_O rises.
                if (sub_q == SW'(1)) begin
                    color_d = plane_bits;
                end
                if (sub_q == SW'(2 * CLK_DIV)) begin
                    sub_d = '0;
                    if (col_q == XW'(COLS - 1)) begin
                        col_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_BLANK;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt_q == '0) begin
                    ra_d = 4'(row_q);
                end
                if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_LATCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                LATCH   = 1'b1;
                cnt_d   = '0;
                state_d = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                OE = 1'b0;
                if (cnt_q == disp_last) begin
                    cnt_d = '0;
                    sub_d = '0;
                    col_d = '0;
                    if (plane_q == PW'(BIT_DEPTH - 1)) begin
                        plane_d = '0;
                        row_d   = (row_q == RW'(ROWS_HALF - 1)) ? '0 : row_q + 1'b1;
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                    state_d = EN_I ? ST_SHIFT : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            plane_q <= '0;
            col_q   <= '0;
            sub_q   <= '0;
            cnt_q   <= '0;
            ra_q    <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            col_q   <= col_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            ra_q    <= ra_d;
            color_q <= color_d;
        end
    end

    assign RD_ADDR_O     = AW'(int'(row_q) * COLS + int'(col_q));
    assign {R0, G0, B0, R1, G1, B1} = color_d;
    assign {RD, RC, RB, RA} = ra_q;
    assign FRAME_START_O = (state_q == ST_SHIFT) && (sub_q == '0) && (col_q == '0)
                           && (row_q == '0) && (plane_q == '0);
    assign BUSY_O        = (state_q != ST_IDLE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl: random framebuffer contents and enable-drop points,
// compared cycle by cycle against a plane-timeline model built from the panel timing rules.
module tb_hub75_scan_ctrl;

    localparam int COLS      = 32;
    localparam int ROWS      = 16;
    localparam int BD        = 4;
    localparam int CLK_DIV   = 1;
    localparam int OE_BASE   = 32;
    localparam int BLANK     = 2;
    localparam int AW        = 9;
    localparam int SHIFT_CYC = COLS * (2 * CLK_DIV + 1);
    localparam int NEVER     = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic rd_en;
    logic [AW-1:0] rd_addr;
    logic [6*BD-1:0] rd_data;
    logic r0, g0, b0, r1, g1, b1;
    logic pin_ra, pin_rb, pin_rc, pin_rd;
    logic clk_o, latch, oe, fs, busy;
    logic [2:0] dbg_state;

    logic [23:0] fb [512];
    logic [AW-1:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int frame_cyc;

    logic s_clk, s_latch, s_fs, s_rd;
    logic [AW-1:0] s_addr;
    logic [3:0] s_ra;
    logic [5:0] s_rgb;

    typedef struct {
        bit idle;
        int g;
        int row;
        int plane;
        int u;
    } pos_t;

    always #5 clk = ~clk;

    hub75_scan_ctrl #(
        .COLS(COLS), .ROWS_HALF(ROWS), .BIT_DEPTH(BD), .CLK_DIV(CLK_DIV),
        .OE_BASE(OE_BASE), .BLANK_CYCLES(BLANK), .AW(AW)
    ) dut (
        .CLK_I(clk), .RST_I(rst), .EN_I(en),
        .RD_EN_O(rd_en), .RD_ADDR_O(rd_addr), .RD_DATA_I(rd_data),
        .R0(r0), .G0(g0), .B0(b0), .R1(r1), .G1(g1), .B1(b1),
        .RA(pin_ra), .RB(pin_rb), .RC(pin_rc), .RD(pin_rd),
        .CLK_O(clk_o), .LATCH(latch), .OE(oe),
        .FRAME_START_O(fs), .BUSY_O(busy), .dbg_state_o(dbg_state)
    );

    // Framebuffer memory: word for the strobed address appears on the next cycle.
    always @(posedge clk) begin
        if (rd_en) rd_data <= fb[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t state=%0d)", tag, got, exp, $time, dbg_state);
    endtask

    function automatic int plane_len(input int b);
        return SHIFT_CYC + BLANK + 1 + (OE_BASE << b);
    endfunction

    // Walk the plane timeline from the start of the run; anything past the stop plane is idle.
    function automatic pos_t locate(input int t, input int g_stop);
        pos_t p;
        int g, start, len;
        p.idle = 0; p.g = 0; p.row = 0; p.plane = 0; p.u = 0;
        g     = (t / frame_cyc) * ROWS * BD;
        start = (t / frame_cyc) * frame_cyc;
        for (int i = 0; i <= ROWS * BD; i++) begin
            if (g > g_stop) begin
                p.idle = 1;
                return p;
            end
            len = plane_len(g % BD);
            if (t < start + len) begin
                p.g = g; p.row = (g / BD) % ROWS; p.plane = g % BD; p.u = t - start;
                return p;
            end
            start += len;
            g++;
        end
        return p;
    endfunction

    function automatic logic [5:0] fb_bits(input logic [AW-1:0] a, input int b);
        logic [23:0] s;
        s = fb[a] >> b;
        return {s[20], s[16], s[12], s[8], s[4], s[0]};
    endfunction

    task automatic step(input int t, input int g_stop);
        pos_t p;
        logic [5:0] ctl_got, ctl_exp;
        int col, ph, base;
        @(negedge clk);
        s_clk = clk_o; s_latch = latch; s_fs = fs; s_rd = rd_en; s_addr = rd_addr;
        s_ra  = {pin_rd, pin_rc, pin_rb, pin_ra};
        s_rgb = {r0, g0, b0, r1, g1, b1};
        ctl_got = {busy, fs, rd_en, clk_o, latch, oe};
        if (t < 0) p.idle = 1;
        else p = locate(t, g_stop);
        if (p.idle) begin
            check("ctl_idle", 32'(ctl_got), 32'(6'b000001));
        end else begin
            base = p.row * COLS;
            if (p.u < SHIFT_CYC) begin
                col = p.u / (2 * CLK_DIV + 1);
                ph  = p.u % (2 * CLK_DIV + 1);
                ctl_exp = {1'b1, (p.u == 0 && p.row == 0 && p.plane == 0), (ph == 0),
                           (ph > CLK_DIV), 1'b0, 1'b1};
                check("ctl_shift", 32'(ctl_got), 32'(ctl_exp));
                if (ph == 0) check("rd_addr", 32'(s_addr), 32'(base + col));
                else check("rgb_shift", 32'(s_rgb), 32'(fb_bits(AW'(base + col), p.plane)));
            end else if (p.u < SHIFT_CYC + BLANK) begin
                check("ctl_blank", 32'(ctl_got), 32'(6'b100001));
                check("rgb_hold", 32'(s_rgb), 32'(fb_bits(AW'(base + COLS - 1), p.plane)));
            end else if (p.u == SHIFT_CYC + BLANK) begin
                check("ctl_latch", 32'(ctl_got), 32'(6'b100011));
                check("ra_latch", 32'(s_ra), 32'(p.row));
            end else begin
                check("ctl_disp", 32'(ctl_got), 32'(6'b100000));
                check("ra_disp", 32'(s_ra), 32'(p.row));
                check("rgb_disp", 32'(s_rgb), 32'(fb_bits(AW'(base + COLS - 1), p.plane)));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_episode(input int n_cycles, input int td, input bit sb_on, input bit after_reset);
        pos_t pd;
        int g_stop;
        int clk_rises = 0;
        int fs_last = -1;
        int fs_gap = -1;
        int rd_count = 0;
        int rd_wide = 0;
        bit latch_seen = 0;
        bit prev_clk = 0;
        bit prev_rd = 0;
        logic [AW-1:0] exp_addr;
        g_stop = NEVER;
        if (td >= 0) begin
            pd = locate(td, NEVER);
            g_stop = pd.g;
        end
        en = 1'b1;
        step(-1, g_stop);
        if (after_reset) begin
            check("reset_ra", 32'(s_ra), 32'(0));
            check("reset_rgb", 32'(s_rgb), 32'(0));
        end
        for (int t = 0; t < n_cycles; t++) begin
            en = (td < 0) || (t < td);
            step(t, g_stop);
            if (sb_on) begin
                if (s_clk && !prev_clk && !latch_seen) clk_rises++;
                if (s_latch) latch_seen = 1;
                if (s_fs) begin
                    if (fs_last >= 0) fs_gap = t - fs_last;
                    fs_last = t;
                end
                if (s_rd && prev_rd) rd_wide++;
                if (s_rd && t < frame_cyc) begin
                    rd_count++;
                    if (exp_q.size() > 0) begin
                        exp_addr = exp_q.pop_front();
                        check("sb_addr", 32'(s_addr), 32'(exp_addr));
                    end
                end
                prev_clk = s_clk;
                prev_rd  = s_rd;
            end
        end
        en = 1'b0;
        if (sb_on) begin
            check("clk_rises_before_latch", clk_rises, 32);
            check("frame_start_gap", fs_gap, 14016);
            check("reads_per_frame", rd_count, 2048);
            check("sb_leftover", exp_q.size(), 0);
            check("rd_pulse_wide", rd_wide, 0);
        end
    endtask

    initial begin
        pos_t p;
        int td, n;
        frame_cyc = 0;
        for (int b = 0; b < BD; b++) frame_cyc += ROWS * plane_len(b);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed pattern: only R0 bit 0 set, alternating with column parity.
        for (int a = 0; a < 512; a++) fb[AW'(a)] = ((a % COLS) % 2 == 1) ? 24'h100000 : 24'h000000;
        for (int r = 0; r < ROWS; r++)
            for (int b = 0; b < BD; b++)
                for (int c = 0; c < COLS; c++) exp_q.push_back(AW'(r * COLS + c));
        run_episode(frame_cyc + 121, -1, 1'b1, 1'b1);

        // Reset lands mid-DISPLAY of the second frame's first plane.
        rst = 1'b1;
        en  = 1'b1;
        step(frame_cyc + 121, NEVER);
        rst = 1'b0;

        // Enable drops during plane 1 shift: plane 1 completes, then idle.
        for (int a = 0; a < 512; a++) fb[AW'(a)] = 24'($urandom);
        td = plane_len(0) + int'($urandom_range(0, SHIFT_CYC - 1));
        run_episode(plane_len(0) + plane_len(1) + 40, td, 1'b0, 1'b1);

        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 512; a++) fb[AW'(a)] = 24'($urandom);
            td = int'($urandom_range(0, 3000));
            p  = locate(td, NEVER);
            n  = td - p.u + plane_len(p.plane) + int'($urandom_range(5, 40));
            run_episode(n, td, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
